// File: rtl/slice_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit ripple slice processes one
// nibble per clock, LSB first, under an IDLE/RUN/DONE start-busy-done handshake.
module slice_adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shadow;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [IDX_W+1:0] nib_lo;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       slice_res;
  logic [WIDTH-1:0] shadow_next;
  logic             accept;

  // Four chained full adders; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] slice_add(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       cin);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[4], s};
  endfunction

  assign nib_lo    = {idx, 2'b00};
  assign slice_res = slice_add(nib_a, nib_b, carry_q);
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // The final nibble is merged combinationally so Sum loads the complete
  // result on the same edge that writes the last shadow nibble.
  always_comb begin
    nib_a       = op_a[nib_lo +: 4];
    nib_b       = op_b[nib_lo +: 4];
    shadow_next = shadow;
    shadow_next[nib_lo +: 4] = slice_res[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      shadow  <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      Sum     <= '0;
      Carry   <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          shadow  <= shadow_next;
          carry_q <= slice_res[4];
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            Sum   <= shadow_next;
            Carry <= slice_res[4];
            state <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (accept) begin
            op_a    <= A;
            op_b    <= B;
            carry_q <= Cin;
            idx     <= '0;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Scoreboard bench for slice_adder_sequencer at WIDTH = 4, 16 and 32.
module tb_slice_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_drv = 1'b0;
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        cin_drv = 1'b0;
  int          cur_w = 16;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic start4, start16, start32;
  logic busy4, busy16, busy32;
  logic done4, done16, done32;
  logic carry4, carry16, carry32;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    int          t_acc;
    int          ns;
  } sb_t;
  sb_t sb_q[$];

  assign start4  = start_drv && (cur_w == 4);
  assign start16 = start_drv && (cur_w == 16);
  assign start32 = start_drv && (cur_w == 32);

  slice_adder_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a_drv[3:0]), .B(b_drv[3:0]),
    .Cin(cin_drv), .busy(busy4), .done(done4), .Sum(sum4), .Carry(carry4));
  slice_adder_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a_drv[15:0]), .B(b_drv[15:0]),
    .Cin(cin_drv), .busy(busy16), .done(done16), .Sum(sum16), .Carry(carry16));
  slice_adder_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .A(a_drv), .B(b_drv),
    .Cin(cin_drv), .busy(busy32), .done(done32), .Sum(sum32), .Carry(carry32));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      32:      return busy32;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      32:      return done32;
      default: return done16;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    case (w)
      4:       return {28'd0, sum4};
      32:      return sum32;
      default: return {16'd0, sum16};
    endcase
  endfunction

  function automatic logic get_carry(input int w);
    case (w)
      4:       return carry4;
      32:      return carry32;
      default: return carry16;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Monitor: every done pops one expected result and checks value and latency.
  always @(negedge clk) begin
    if (rst_n && get_done(cur_w)) begin
      sb_t e;
      check_val("busy_at_done", get_busy(cur_w), 1'b0);
      check_val("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("sum", get_sum(cur_w), e.sum);
        check_val("carry", get_carry(cur_w), e.carry);
        check_val("latency", cyc - e.t_acc, e.ns);
      end
    end
  end

  // Called at a negedge with the selected DUT in IDLE or DONE; returns at
  // the negedge where done is high (or after a bounded wait).
  task automatic issue_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input bit disturb);
    sb_t         e;
    logic [63:0] full;
    int          ns;
    int          busy_n;
    bit          got;
    ns        = w / 4;
    a_drv     = a;
    b_drv     = b;
    cin_drv   = c;
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    full    = (64'(a) & mask(w)) + (64'(b) & mask(w)) + 64'(c);
    e.sum   = 32'(full & mask(w));
    e.carry = full[w];
    e.t_acc = cyc;
    e.ns    = ns;
    sb_q.push_back(e);
    start_drv = 1'b0;
    @(negedge clk);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 4 * ns + 8; i++) begin
      if (get_done(w)) begin
        got = 1'b1;
        break;
      end
      if (get_busy(w)) busy_n++;
      if (disturb) begin
        a_drv     = $urandom;
        b_drv     = $urandom;
        cin_drv   = ~cin_drv;
        start_drv = (i == 1);
      end
      @(negedge clk);
    end
    start_drv = 1'b0;
    check_val("done_seen", got, 1'b1);
    check_val("busy_cycles", busy_n, ns);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy16, 1'b0);
    check_val("rst_done", done16, 1'b0);
    check_val("rst_sum", sum16, 16'h0);
    check_val("rst_carry", carry16, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_busy", busy16, 1'b0);
      check_val("idle_done", done16, 1'b0);
    end

    // Directed WIDTH=16 operations
    issue_op(16, 32'h00FF, 32'h0001, 1'b0, 1'b0);
    check_val("t2_sum", sum16, 16'h0100);
    @(negedge clk);
    issue_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    check_val("t3a_carry", carry16, 1'b1);
    @(negedge clk);
    issue_op(16, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    check_val("t3b_sum", sum16, 16'hFFFF);
    @(negedge clk);
    issue_op(16, 32'h1234, 32'h4321, 1'b1, 1'b1);
    check_val("t4_sum", sum16, 16'h5556);
    issue_op(16, 32'hABCD, 32'h1111, 1'b0, 1'b0);

    // Abort mid-RUN
    @(negedge clk);
    a_drv     = 32'hFFFF;
    b_drv     = 32'h0001;
    cin_drv   = 1'b0;
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy16, 1'b0);
    check_val("abort_done", done16, 1'b0);
    check_val("abort_sum", sum16, 16'h0);
    check_val("abort_carry", carry16, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("post_abort_done", done16, 1'b0);
    end
    issue_op(16, 32'h0003, 32'h0004, 1'b0, 1'b0);
    check_val("t5_sum", sum16, 16'h0007);

    // Random ops with random gaps for each width
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      cur_w = (k == 0) ? 4 : ((k == 1) ? 16 : 32);
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        issue_op(cur_w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
